// File: rtl/gated_bus_ctrl.sv
// N-source internal bus driver for the LC-3 datapath. The lowest-index active gate wins.
// Optional bus keeper, registered bus/source index, and sticky conflict detection with a saturating counter.
//
// Output qualifier semantics: Src_valid is a one-cycle qualifier for Bus_q and Src_idx.
// When it is high, those registers were loaded from a cycle with at least one gate active.
// There is no ready: the bus is a broadcast, so consumers sample whenever they see Src_valid.
module gated_bus_ctrl #(
  parameter  int WIDTH  = 16,
  parameter  int N_SRC  = 4,
  parameter  int KEEPER = 1,
  parameter  int CNT_W  = 8,
  localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_SRC*WIDTH-1:0] Din,
  input  logic [N_SRC-1:0]       Gate,
  input  logic                   ClrErr,
  output logic [WIDTH-1:0]       Bus,
  output logic [WIDTH-1:0]       Bus_q,
  output logic [IDX_W-1:0]       Src_idx,
  output logic                   Src_valid,
  output logic                   Conflict,
  output logic                   ConflictErr,
  output logic [CNT_W-1:0]       ConflictCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             any_act;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] keeper;
  logic [WIDTH-1:0] idle_val;

  // Scan from the top down so that the last assignment is the lowest active index.
  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (Gate[i]) win_idx = IDX_W'(i);
    end
  end

  assign any_act  = |Gate;
  assign win_data = Din[int'(win_idx)*WIDTH +: WIDTH];
  // Clearing the lowest set bit leaves something only when two or more gates are active.
  assign Conflict = |(Gate & (Gate - N_SRC'(1)));

  generate
    if (KEEPER != 0) begin : g_keeper
      always_ff @(posedge Clk) begin
        if (Reset)        keeper <= '0;
        else if (any_act) keeper <= win_data;
      end
      assign idle_val = keeper;
    end else begin : g_no_keeper
      assign keeper   = '0;
      assign idle_val = keeper;
    end
  endgenerate

  assign Bus = any_act ? win_data : idle_val;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Bus_q     <= '0;
      Src_idx   <= '0;
      Src_valid <= 1'b0;
    end else begin
      Bus_q     <= Bus;
      Src_valid <= any_act;
      if (any_act) Src_idx <= win_idx;
    end
  end

  // A conflict in the same cycle as ClrErr restarts the count at one rather than being lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ConflictErr <= 1'b0;
      ConflictCnt <= '0;
    end else if (Conflict) begin
      ConflictErr <= 1'b1;
      if (ClrErr)                      ConflictCnt <= CNT_W'(1);
      else if (ConflictCnt != CNT_MAX) ConflictCnt <= ConflictCnt + CNT_W'(1);
    end else if (ClrErr) begin
      ConflictErr <= 1'b0;
      ConflictCnt <= '0;
    end
  end

endmodule

// File: doc/gated_bus_ctrl.md
# gated_bus_ctrl

Parametrised N-source, W-bit internal datapath bus driver for the LC-3 datapath, replacing the fixed 4-source gate mux that sits between the ALU, PC, MARMUX, MDR and the bus loads. It resolves the one-hot gate signals into a single bus value without tristates and, optionally, holds the last driven value (bus keeper) when no gate is active. It also registers the bus and its source index, and detects, counts and latches multi-driver conflicts for debug and verification.

## Interface
- WIDTH, 16, bus width in bits (≥1)
- N_SRC, 4, number of sources (≥2); source i is ALU=0, PC=1, MARMUX=2, MDR=3 in the LC-3 instance
- KEEPER, 1, idle behaviour: 0 = drive all-zero when no gate active, 1 = drive last value latched from an active gate
- CNT_W, 8, conflict counter width (saturating)

- Clk  in  1  clock, rising-edge
- Reset  in  1  synchronous, active-high
- Din  in  N_SRC*WIDTH  packed sources; source i occupies bits [i*WIDTH +: WIDTH]
- Gate  in  N_SRC  gate enables, intended one-hot; bit i gates source i
- ClrErr  in  1  clears sticky ConflictErr and ConflictCnt
- Bus  out  WIDTH  combinational bus value
- Bus_q  out  WIDTH  Bus registered one cycle
- Src_idx  out  max(1,$clog2(N_SRC))  index of the source that drove the most recent active cycle
- Src_valid  out  1  high for one cycle after any cycle with ≥1 gate active
- Conflict  out  1  combinational, high when ≥2 gates active
- ConflictErr  out  1  sticky conflict flag
- ConflictCnt  out  CNT_W  saturating count of conflict cycles

## Operation
- Winner selection: lowest-index active gate wins. Exactly one gate active means that source drives; with ≥2 active the lowest index still drives and Conflict=1.
- Bus when some gate is active = Din slice of the winner, same cycle, no register.
- Bus when no gate is active = 0 if KEEPER=0, else keeper register.
- Keeper register: loads the winner's Din at the rising edge when ≥1 gate is active; otherwise holds.
- Bus_q <= Bus every cycle.
- Src_idx <= winner index when ≥1 gate is active; otherwise holds.
- Src_valid <= (Gate != 0).
- ConflictErr <= 1 on any conflict cycle. Otherwise it is cleared by ClrErr, else it holds.
- ConflictCnt increments by 1 on a conflict cycle and saturates at 2^CNT_W−1 (no wrap). ClrErr zeroes it.
- ClrErr in the same cycle as a conflict: the conflict wins. ConflictErr=1 and ConflictCnt = 1 (clear, then count this cycle).
- Reset dominates ClrErr and conflicts.
- No internal state machine beyond the registers above. All registers are single-cycle update.

## Timing
- Reset values (after the Reset edge): keeper=0, Bus_q=0, Src_idx=0, Src_valid=0, ConflictErr=0, ConflictCnt=0.
- Bus and Conflict stay combinational during Reset: they follow Gate/Din. When idle, Bus shows the keeper (0 once the Reset edge has occurred).
- Reset asserted mid-transfer: all registers clear at that edge. A gate active in the Reset cycle is not latched into keeper, Src_idx or the counters.
- Latency: Gate/Din→Bus is 0 cycles. Gate/Din→Bus_q, Src_idx and Src_valid is 1 cycle. Conflict→ConflictErr/ConflictCnt is 1 cycle.
- Bus changes only with Gate/Din (or the keeper after an edge). There is no glitch requirement beyond standard synchronous design.
- Gate deasserted after an active cycle, KEEPER=1: Bus holds the last driven value from the very next cycle, with no zero bubble.

## Test plan
- Reset, then Gate=0001, Din ALU=16'h1234 -> Bus=16'h1234 the same cycle; next cycle Bus_q=16'h1234, Src_idx=0, Src_valid=1; Conflict stays 0.
- KEEPER=1: drive MDR=16'hBEEF with Gate=1000 for 1 cycle, then Gate=0000 for 3 cycles -> Bus=16'hBEEF throughout, Src_idx=3, Src_valid falls to 0 one cycle after the gate drops. With KEEPER=0 the same stimulus gives Bus=16'h0000 while idle.
- Gate=0110, PC=16'h3000, MARMUX=16'h4000 -> Bus=16'h3000 and Conflict=1 the same cycle; next cycle ConflictErr=1, ConflictCnt=1, Src_idx=1.
- CNT_W=2: hold Gate=1111 for 5 cycles -> ConflictCnt goes 1,2,3,3,3. Then ClrErr=1 with Gate=0001 -> next cycle ConflictErr=0, ConflictCnt=0.
- ClrErr=1 together with Gate=0011 -> next cycle ConflictErr=1, ConflictCnt=1.
- Mid-run Reset with Gate=0100, MARMUX=16'h00FF -> Bus=16'h00FF combinationally; after the edge Bus_q=0, Src_idx=0, Src_valid=0, counters are 0, and keeper=0 (Bus=0 once Gate=0000).
